// File: rtl/mmio_console.sv
// ============================================================================
//  Module   : mmio_console
//  Purpose  : Memory-mapped console responder. Decodes a 32-byte window on
//             the core data bus, serves loads combinationally, buffers stored
//             bytes in a TX FIFO drained over a valid/ready byte stream, and
//             provides a cycle counter, a scratch register and an empty-FIFO
//             interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic        mem_we,
  output logic [31:0] mem_data_out,
  output logic        mem_data_oe,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  localparam logic [2:0] c_REG_TXDATA  = 3'd0;
  localparam logic [2:0] c_REG_STATUS  = 3'd1;
  localparam logic [2:0] c_REG_CYCLE   = 3'd2;
  localparam logic [2:0] c_REG_SCRATCH = 3'd3;
  localparam logic [2:0] c_REG_IRQEN   = 3'd4;

  // Registered state
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0] count_q,  count_d;
  logic            ovf_q,    ovf_d;
  logic [31:0]     cycle_q,  cycle_d;
  logic [31:0]     scratch_q, scratch_d;
  logic            irq_en_q, irq_en_d;
  logic [0:0]      state_q,  state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            irq_q,    irq_d;

  // Decode and handshake wires
  logic        w_sel;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_push_req;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte-lane bits are meaningless for full-word accesses
  assign w_unused = ^mem_addr[1:0];

  assign w_sel      = (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign w_idx      = mem_addr[4:2];
  assign w_wr       = w_sel & mem_we;
  assign w_push_req = w_wr & (w_idx == c_REG_TXDATA);

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_CW'(FIFO_DEPTH));
  assign w_head  = fifo_q[rd_ptr_q];

  // The drain side pops whenever it can hand a byte to the output register:
  // from IDLE unconditionally, from SEND only on an accepting edge.
  assign w_pop     = ~w_empty & ((state_q == c_IDLE) | tx_ready);
  // A pop on the same edge frees the slot, so a store into a full FIFO is kept
  assign w_push_ok = w_push_req & (~w_full | w_pop);

  // Pointer, occupancy, sticky overflow and register-file next state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    scratch_d = scratch_q;
    irq_en_d  = irq_en_q;
    cycle_d   = cycle_q + 32'd1;

    if (w_push_ok) wr_ptr_d = wr_ptr_q + c_AW'(1);
    if (w_pop)     rd_ptr_d = rd_ptr_q + c_AW'(1);

    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + c_CW'(1);
      2'b01:   count_d = count_q - c_CW'(1);
      default: count_d = count_q;
    endcase

    if (w_push_req & ~w_push_ok) ovf_d = 1'b1;

    if (w_wr) begin
      case (w_idx)
        c_REG_STATUS:  if (mem_data_in[2]) ovf_d = 1'b0;
        c_REG_CYCLE:   cycle_d   = mem_data_in;
        c_REG_SCRATCH: scratch_d = mem_data_in;
        c_REG_IRQEN:   irq_en_d  = mem_data_in[0];
        default:       ;
      endcase
    end
  end

  // Drain FSM: load the output register from the FIFO head and hold it
  // stable until the downstream accepts it
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      c_IDLE: begin
        if (!w_empty) begin
          tx_data_d  = w_head;
          tx_valid_d = 1'b1;
          state_d    = c_SEND;
        end
      end
      c_SEND: begin
        if (tx_ready) begin
          if (!w_empty) begin
            tx_data_d = w_head;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = c_IDLE;
          end
        end
      end
      default: begin
        state_d    = c_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // Interrupt sampled from the current state; lags its inputs by one edge
  assign irq_d = irq_en_q & w_empty & ~tx_valid_q;

  // Control and register state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      cycle_q    <= '0;
      scratch_q  <= '0;
      irq_en_q   <= 1'b0;
      state_q    <= c_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
      irq_en_q   <= irq_en_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      irq_q      <= irq_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push_ok) fifo_q[wr_ptr_q] <= mem_data_in[7:0];
  end

  // Status word and combinational load mux
  always_comb begin
    w_status                = '0;
    w_status[0]             = w_empty;
    w_status[1]             = w_full;
    w_status[2]             = ovf_q;
    w_status[8 +: c_CW]     = count_q;

    w_rdata = '0;
    case (w_idx)
      c_REG_STATUS:  w_rdata = w_status;
      c_REG_CYCLE:   w_rdata = cycle_q;
      c_REG_SCRATCH: w_rdata = scratch_q;
      c_REG_IRQEN:   w_rdata = {31'd0, irq_en_q};
      default:       w_rdata = '0;
    endcase
  end

  assign mem_data_oe  = w_sel & ~mem_we;
  assign mem_data_out = mem_data_oe ? w_rdata : '0;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign irq          = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_console.sv
// ============================================================================
//  Module   : tb_mmio_console
//  Purpose  : Directed self-checking bench for mmio_console (DEPTH 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_console;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;
  logic        mem_data_oe;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] c_TXDATA  = 32'hFFFF_FF00;
  localparam logic [31:0] c_STATUS  = 32'hFFFF_FF04;
  localparam logic [31:0] c_CYCLE   = 32'hFFFF_FF08;
  localparam logic [31:0] c_SCRATCH = 32'hFFFF_FF0C;
  localparam logic [31:0] c_IRQEN   = 32'hFFFF_FF10;
  localparam logic [31:0] c_OUTSIDE = 32'h1234_5678;

  mmio_console #(
    .BASE_ADDR  (32'hFFFF_FF00),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out),
    .mem_data_oe  (mem_data_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One store, committed on the next rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr    = a;
    mem_data_in = d;
    mem_we      = 1'b1;
    tick();
    mem_we      = 1'b0;
    mem_addr    = c_OUTSIDE;
    mem_data_in = '0;
  endtask

  // Combinational load, no clock edge consumed
  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem_addr = a;
    mem_we   = 1'b0;
    #1;
    check(tag, mem_data_out, exp);
    mem_addr = c_OUTSIDE;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_addr    = c_OUTSIDE;
    mem_data_in = '0;
    mem_we      = 1'b0;
    tx_ready    = 1'b0;

    // ---- reset state ----
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("rst_status", c_STATUS, 32'h0000_0001);

    // ---- reset mid-SEND ----
    wr(c_TXDATA, 32'h55);
    tick();
    check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
    check("pre_rst_data", {24'd0, tx_data}, 32'h55);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_data", {24'd0, tx_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk_rd("midrst_status", c_STATUS, 32'h0000_0001);
    chk_rd("cycle0", c_CYCLE, 32'd0);
    tick();
    chk_rd("cycle1", c_CYCLE, 32'd1);
    tick();
    chk_rd("cycle2", c_CYCLE, 32'd2);

    // ---- single byte with 3-cycle stall ----
    tx_ready = 1'b0;
    wr(c_TXDATA, 32'h41);
    check("sb_valid_e0", {31'd0, tx_valid}, 32'd0);
    tick();
    check("sb_valid_e1", {31'd0, tx_valid}, 32'd1);
    check("sb_data_e1", {24'd0, tx_data}, 32'h41);
    chk_rd("sb_status", c_STATUS, 32'h0000_0001);
    tick();
    tick();
    check("sb_valid_stall", {31'd0, tx_valid}, 32'd1);
    check("sb_data_stall", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    tick();
    check("sb_valid_done", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // ---- overflow ----
    for (int i = 1; i <= 6; i++) wr(c_TXDATA, 32'(i));
    chk_rd("ovf_status", c_STATUS, 32'h0000_0406);
    check("ovf_head", {24'd0, tx_data}, 32'h01);
    wr(c_STATUS, 32'h4);
    chk_rd("ovf_cleared", c_STATUS, 32'h0000_0402);

    // ---- store into full FIFO on a popping edge ----
    tx_ready = 1'b1;
    wr(c_TXDATA, 32'h07);
    check("coll_data", {24'd0, tx_data}, 32'h02);
    chk_rd("coll_status", c_STATUS, 32'h0000_0402);
    tick(); check("drain_03", {24'd0, tx_data}, 32'h03);
    tick(); check("drain_04", {24'd0, tx_data}, 32'h04);
    tick(); check("drain_05", {24'd0, tx_data}, 32'h05);
    check("drain_valid", {31'd0, tx_valid}, 32'd1);
    tick(); check("drain_07", {24'd0, tx_data}, 32'h07);
    tick(); check("drain_end", {31'd0, tx_valid}, 32'd0);
    chk_rd("drain_status", c_STATUS, 32'h0000_0001);

    // ---- back-to-back with tx_ready held high ----
    wr(c_TXDATA, 32'h10);
    check("b2b_v0", {31'd0, tx_valid}, 32'd0);
    wr(c_TXDATA, 32'h11);
    check("b2b_d10", {23'd0, tx_valid, tx_data}, 32'h110);
    wr(c_TXDATA, 32'h12);
    check("b2b_d11", {23'd0, tx_valid, tx_data}, 32'h111);
    tick();
    check("b2b_d12", {23'd0, tx_valid, tx_data}, 32'h112);
    tick();
    check("b2b_idle", {31'd0, tx_valid}, 32'd0);

    // ---- CYCLE wrap, SCRATCH, unmapped and out-of-window ----
    wr(c_CYCLE, 32'hFFFF_FFFE);
    chk_rd("cyc_load", c_CYCLE, 32'hFFFF_FFFE);
    tick();
    chk_rd("cyc_max", c_CYCLE, 32'hFFFF_FFFF);
    tick();
    chk_rd("cyc_wrap", c_CYCLE, 32'h0000_0000);
    wr(c_SCRATCH, 32'hDEAD_BEEF);
    chk_rd("scratch", c_SCRATCH, 32'hDEAD_BEEF);
    chk_rd("scratch_lane", 32'hFFFF_FF0E, 32'hDEAD_BEEF);
    wr(32'hFFFF_FF14, 32'h1234_5678);
    chk_rd("unmapped14", 32'hFFFF_FF14, 32'd0);
    chk_rd("txdata_rd", c_TXDATA, 32'd0);
    mem_addr = 32'hFFFF_FF14;
    #1;
    check("oe_inwin", {31'd0, mem_data_oe}, 32'd1);
    mem_addr = c_OUTSIDE;
    #1;
    check("oe_outwin", {31'd0, mem_data_oe}, 32'd0);
    check("data_outwin", mem_data_out, 32'd0);
    mem_addr = c_SCRATCH;
    mem_we   = 1'b1;
    #1;
    check("oe_store", {31'd0, mem_data_oe}, 32'd0);
    mem_we   = 1'b0;
    mem_addr = c_OUTSIDE;

    // ---- interrupt ----
    tx_ready = 1'b0;
    wr(c_IRQEN, 32'hFFFF_FFFF);
    check("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    chk_rd("irqen_rd", c_IRQEN, 32'd1);
    wr(c_TXDATA, 32'h99);
    check("irq_push_e0", {31'd0, irq}, 32'd1);
    tick();
    check("irq_push_e1", {31'd0, irq}, 32'd0);
    check("irq_valid", {31'd0, tx_valid}, 32'd1);
    tick();
    check("irq_sending", {31'd0, irq}, 32'd0);
    tx_ready = 1'b1;
    tick();
    check("irq_hs", {31'd0, irq}, 32'd0);
    check("irq_hs_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    check("irq_back", {31'd0, irq}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
